// File: rtl/ledg_sched_pkg.sv
// Shared types and constants for the green-LED scheduler and its tick generator.
package ledg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int HOLD_W = 8;

    localparam logic [9:0] SCAN_INIT   = 10'b0000000111;
    localparam logic [9:0] SCAN_TURN_R = 10'b0111000000;
    localparam logic [9:0] SCAN_TURN_L = 10'b0000001110;

    // One scanner step: dir=0 rotates toward the MSB, dir=1 toward the LSB.
    function automatic logic [9:0] scan_step(input logic [9:0] s, input logic dir);
        return dir ? {s[0], s[9:1]} : {s[8:0], s[9]};
    endfunction

endpackage

// File: rtl/ledg_tick_gen.sv
// Free-running prescaler: oTICK pulses for one cycle every TICK_DIV clocks.
module ledg_tick_gen #(
    parameter int TICK_DIV = 2097152
) (
    input  logic iCLK,
    input  logic iRST_n,
    output logic oTICK
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oTICK = (cnt_q == LAST);

endmodule

// File: rtl/ledg_scheduler.sv
// Round-robin time-sharing of the 10-bit green LED bank with an idle bar scanner.
// The scanner exists only when LEDG_SCHED_IDLE_SCAN_EN is defined; otherwise idle LEDs are dark.
module ledg_scheduler
    import ledg_sched_pkg::*;
#(
    parameter int TICK_DIV   = 2097152,
    parameter int HOLD_TICKS = 16
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [1:0] iREQ,
    input  logic [9:0] iPAT0,
    input  logic [9:0] iPAT1,
    output logic [1:0] oGNT,
    output logic [9:0] oLED,
    output logic       oTICK
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
`ifdef LEDG_SCHED_IDLE_SCAN_EN
    localparam logic [9:0] LED_RST = SCAN_INIT;
`else
    localparam logic [9:0] LED_RST = 10'b0;
`endif

    logic tick;

    ledg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .oTICK (tick)
    );

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [9:0]        led_q, led_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rr_last_q, rr_last_d;
    logic              do_grant, new_owner, owner;
    logic [9:0]        idle_led;
`ifdef LEDG_SCHED_IDLE_SCAN_EN
    logic [9:0]        scan_q, scan_d;
    logic              dir_q, dir_d;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        led_d     = led_q;
        hold_d    = hold_q;
        rr_last_d = rr_last_q;
        do_grant  = 1'b0;
        new_owner = 1'b0;
        owner     = (state_q == GNT1);
`ifdef LEDG_SCHED_IDLE_SCAN_EN
        scan_d    = scan_q;
        dir_d     = dir_q;
        idle_led  = scan_q;
`else
        idle_led  = 10'b0;
`endif

        if (tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (iREQ != 2'b00) begin
                    do_grant  = 1'b1;
                    new_owner = (iREQ == 2'b11) ? ~rr_last_q : iREQ[1];
                end else begin
`ifdef LEDG_SCHED_IDLE_SCAN_EN
                    // Direction is decided from the pre-shift value; the shift uses the old dir.
                    if (tick) begin
                        if (scan_q == SCAN_TURN_R) begin
                            dir_d = 1'b1;
                        end else if (scan_q == SCAN_TURN_L) begin
                            dir_d = 1'b0;
                        end
                        scan_d = scan_step(scan_q, dir_q);
                    end
                    led_d = scan_d;
`else
                    led_d = 10'b0;
`endif
                end
            end
            GNT0, GNT1: begin
                if ((hold_q == '0) && iREQ[~owner]) begin
                    do_grant  = 1'b1;
                    new_owner = ~owner;
                end else if ((hold_q == '0) && !iREQ[owner]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    led_d   = idle_led;
                end else begin
                    led_d = owner ? iPAT1 : iPAT0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                led_d   = idle_led;
            end
        endcase

        // A fresh grant reloads the hold count outright, overriding any tick decrement.
        if (do_grant) begin
            state_d   = new_owner ? GNT1 : GNT0;
            gnt_d     = new_owner ? 2'b10 : 2'b01;
            led_d     = new_owner ? iPAT1 : iPAT0;
            hold_d    = HOLD_LOAD;
            rr_last_d = new_owner;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            led_q     <= LED_RST;
            hold_q    <= '0;
            rr_last_q <= 1'b1;
`ifdef LEDG_SCHED_IDLE_SCAN_EN
            scan_q    <= SCAN_INIT;
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            led_q     <= led_d;
            hold_q    <= hold_d;
            rr_last_q <= rr_last_d;
`ifdef LEDG_SCHED_IDLE_SCAN_EN
            scan_q    <= scan_d;
            dir_q     <= dir_d;
`endif
        end
    end

    assign oGNT  = gnt_q;
    assign oLED  = led_q;
    assign oTICK = tick;

endmodule

// File: tb/tb_ledg_scheduler.sv
// Scoreboard bench for ledg_scheduler: a cycle model predicts each output, a queue pairs it with the DUT.
// Follows LEDG_SCHED_IDLE_SCAN_EN the same way the design does.
module tb_ledg_scheduler;

    localparam int TDIV = 4;
    localparam int HOLD = 2;
`ifdef LEDG_SCHED_IDLE_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif
    localparam logic [9:0] RST_LED = SCAN_ON ? 10'h007 : 10'h000;

    logic       iCLK   = 1'b0;
    logic       iRST_n = 1'b0;
    logic [1:0] iREQ   = 2'b00;
    logic [9:0] iPAT0  = 10'h000;
    logic [9:0] iPAT1  = 10'h000;
    logic [1:0] oGNT;
    logic [9:0] oLED;
    logic       oTICK;

    ledg_scheduler #(.TICK_DIV(TDIV), .HOLD_TICKS(HOLD)) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .iREQ  (iREQ),
        .iPAT0 (iPAT0),
        .iPAT1 (iPAT1),
        .oGNT  (oGNT),
        .oLED  (oLED),
        .oTICK (oTICK)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [1:0] gnt;
        logic [9:0] led;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state (owner -1 means idle)
    int         m_cnt, m_own, m_hold, m_rr;
    logic [9:0] m_scan;
    logic       m_dir;
    logic [1:0] m_gnt;
    logic [9:0] m_led;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt  = 0;
        m_own  = -1;
        m_hold = 0;
        m_rr   = 1;
        m_scan = 10'h007;
        m_dir  = 1'b0;
        m_gnt  = 2'b00;
        m_led  = RST_LED;
    endtask

    task automatic modelStep(input logic [1:0] req, input logic [9:0] p0, input logic [9:0] p1);
        bit         tk;
        int         nxt;
        logic [9:0] old;
        tk  = (m_cnt == TDIV - 1);
        nxt = -1;
        if (m_own < 0) begin
            if (req == 2'b11)      nxt = (m_rr == 1) ? 0 : 1;
            else if (req == 2'b01) nxt = 0;
            else if (req == 2'b10) nxt = 1;
            if (nxt < 0) begin
                if (tk && SCAN_ON) begin
                    old    = m_scan;
                    m_scan = m_dir ? {old[0], old[9:1]} : {old[8:0], old[9]};
                    if (old == 10'h1C0)      m_dir = 1'b1;
                    else if (old == 10'h00E) m_dir = 1'b0;
                end
                m_led = SCAN_ON ? m_scan : 10'h000;
            end
        end else begin
            if (m_hold == 0 && req[1 - m_own]) begin
                nxt = 1 - m_own;
            end else if (m_hold == 0 && !req[m_own]) begin
                m_own = -1;
                m_gnt = 2'b00;
                m_led = SCAN_ON ? m_scan : 10'h000;
            end else begin
                m_led = (m_own == 1) ? p1 : p0;
                if (tk && m_hold > 0) m_hold = m_hold - 1;
            end
        end
        if (nxt >= 0) begin
            m_own  = nxt;
            m_rr   = nxt;
            m_gnt  = (nxt == 1) ? 2'b10 : 2'b01;
            m_led  = (nxt == 1) ? p1 : p0;
            m_hold = HOLD;
        end
        m_cnt = tk ? 0 : m_cnt + 1;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs and compare them.
    task automatic applyStimulus(input logic [1:0] req, input logic [9:0] p0, input logic [9:0] p1);
        exp_t e;
        @(negedge iCLK);
        iREQ  = req;
        iPAT0 = p0;
        iPAT1 = p1;
        modelStep(req, p0, p1);
        e.gnt  = m_gnt;
        e.led  = m_led;
        e.tick = (m_cnt == TDIV - 1);
        sb.push_back(e);
        @(posedge iCLK);
        #1;
        e = sb.pop_front();
        checkOutput("sb_gnt", 32'(oGNT), 32'(e.gnt));
        checkOutput("sb_led", 32'(oLED), 32'(e.led));
        checkOutput("sb_tick", 32'(oTICK), 32'(e.tick));
    endtask

    task automatic doAsyncReset();
        #2;
        iRST_n = 1'b0;
        #1;
        checkOutput("arst_gnt", 32'(oGNT), 32'h0);
        checkOutput("arst_led", 32'(oLED), 32'(RST_LED));
        checkOutput("arst_tick", 32'(oTICK), 32'h0);
        modelReset();
        @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] seq [16];
        bit seen00, seen01, seen10;
        int guard;
        seq = '{10'h007, 10'h00E, 10'h01C, 10'h038, 10'h070, 10'h0E0, 10'h1C0, 10'h380,
                10'h1C0, 10'h0E0, 10'h070, 10'h038, 10'h01C, 10'h00E, 10'h007, 10'h00E};
        modelReset();

        #2;
        checkOutput("rst_gnt", 32'(oGNT), 32'h0);
        checkOutput("rst_led", 32'(oLED), 32'(RST_LED));
        checkOutput("rst_tick", 32'(oTICK), 32'h0);
        @(posedge iCLK);
        #1;
        iRST_n = 1'b1;

        // Idle scanner sweep up and back down, one value per tick
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("scan%0d", i), 32'(oLED), SCAN_ON ? 32'(seq[i]) : 32'h0);
            repeat (TDIV) applyStimulus(2'b00, 10'h3FF, 10'h3FF);
        end

        // Single grant, pattern follows with one cycle lag, then release
        applyStimulus(2'b01, 10'h2AA, 10'h0F0);
        checkOutput("sg_gnt", 32'(oGNT), 32'h1);
        checkOutput("sg_led", 32'(oLED), 32'h2AA);
        applyStimulus(2'b01, 10'h155, 10'h0F0);
        checkOutput("sg_led2", 32'(oLED), 32'h155);
        repeat (12) applyStimulus(2'b00, 10'h155, 10'h0F0);
        checkOutput("sg_rel", 32'(oGNT), 32'h0);

        // One-cycle pulse still holds the grant for the minimum time
        applyStimulus(2'b01, 10'h111, 10'h000);
        applyStimulus(2'b00, 10'h122, 10'h000);
        checkOutput("pulse_hold", 32'(oGNT), 32'h1);
        repeat (12) applyStimulus(2'b00, 10'h133, 10'h000);
        checkOutput("pulse_rel", 32'(oGNT), 32'h0);

        // Tie: grants alternate with no idle gap
        seen00 = 0; seen01 = 0; seen10 = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'b11, 10'(i), 10'(10'h200 + i));
            if (oGNT == 2'b00) seen00 = 1;
            if (oGNT == 2'b01) seen01 = 1;
            if (oGNT == 2'b10) seen10 = 1;
        end
        checkOutput("tie_no_idle", 32'(seen00), 32'h0);
        checkOutput("tie_saw01", 32'(seen01), 32'h1);
        checkOutput("tie_saw10", 32'(seen10), 32'h1);

        // Park in GNT1, then reset asynchronously mid-cycle
        guard = 0;
        while (m_own != 1 && guard < 20) begin
            applyStimulus(2'b10, 10'h001, 10'h3C3);
            guard++;
        end
        checkOutput("pre_rst_gnt", 32'(oGNT), 32'h2);
        doAsyncReset();

        applyStimulus(2'b11, 10'h0AA, 10'h055);
        checkOutput("tie_first", 32'(oGNT), 32'h1);
        checkOutput("tie_first_led", 32'(oLED), 32'h0AA);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom));
        end
        repeat (16) applyStimulus(2'b00, 10'h000, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
